alu_ctrl: RTL and testbench

Single-issue sequencer in front of the 32-bit ALU. It accepts one operation per valid/ready handshake, registers the operands and drives the ALU from stable registers. It owns the architectural 4-bit flags register that feeds the ALU `inflags`, and it returns the result through a valid/ready response port. It sits between instruction decode and register-file writeback.

---
 rtl/alu_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// alu_ctrl: single-issue sequencer in front of the 32-bit ALU; owns the architectural flags register.
// Define ALU_CTRL_PIPE_EN to insert a CAPT state that registers the ALU outputs before they are used.
module alu_ctrl #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_opcode,
    input  logic [3:0]       req_cond,
    input  logic [2:0]       req_srctrl,
    input  logic             req_s,
    input  logic [15:0]      req_imvalue,
    input  logic [W-1:0]     req_in1,
    input  logic [W-1:0]     req_in2,

    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_data,
    output logic [3:0]       res_flags,

    output logic [W-1:0]     alu_in1,
    output logic [W-1:0]     alu_in2,
    output logic             alu_s,
    output logic [3:0]       alu_cond,
    output logic [3:0]       alu_opcode,
    output logic [2:0]       alu_srctrl,
    output logic [15:0]      alu_imvalue,
    output logic [3:0]       alu_inflags,
    input  logic [3:0]       alu_outflags,
    input  logic [W-1:0]     alu_result,

    output logic [3:0]       flags,
    input  logic             flags_clr,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // EXEC  | operand registers drive the ALU; its outputs are taken at the end of the cycle
    // CAPT  | pipelined ALU outputs moved into the response and flags (ALU_CTRL_PIPE_EN only)
    // DONE  | response valid and held until res_ready
`ifdef ALU_CTRL_PIPE_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CAPT = 2'd2,
        ST_DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd3
    } state_t;
`endif

    localparam logic [3:0] OP_NOP = 4'b1111;

    state_t             state_q, state_d;

    logic [3:0]         opcode_q, opcode_d;
    logic [3:0]         cond_q, cond_d;
    logic [2:0]         srctrl_q, srctrl_d;
    logic               s_q, s_d;
    logic [15:0]        imvalue_q, imvalue_d;
    logic [W-1:0]       in1_q, in1_d;
    logic [W-1:0]       in2_q, in2_d;

    logic [W-1:0]       res_data_q, res_data_d;
    logic [3:0]         res_flags_q, res_flags_d;
    logic [3:0]         flags_q, flags_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

`ifdef ALU_CTRL_PIPE_EN
    logic [W-1:0]       pipe_result_q, pipe_result_d;
    logic [3:0]         pipe_flags_q, pipe_flags_d;
`endif

    logic               ready_c;
    logic               accept;
    logic               capture;
    logic [W-1:0]       cap_result;
    logic [3:0]         cap_flags;

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        cond_d      = cond_q;
        srctrl_d    = srctrl_q;
        s_d         = s_q;
        imvalue_d   = imvalue_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        res_data_d  = res_data_q;
        res_flags_d = res_flags_q;
        flags_d     = flags_q;
        op_count_d  = op_count_q;
`ifdef ALU_CTRL_PIPE_EN
        pipe_result_d = pipe_result_q;
        pipe_flags_d  = pipe_flags_q;
`endif
        ready_c    = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        cap_result = alu_result;
        cap_flags  = alu_outflags;

        case (state_q)
            ST_IDLE: begin
                ready_c = 1'b1;
            end
            ST_EXEC: begin
`ifdef ALU_CTRL_PIPE_EN
                pipe_result_d = alu_result;
                pipe_flags_d  = alu_outflags;
                state_d       = ST_CAPT;
`else
                capture = 1'b1;
                state_d = ST_DONE;
`endif
            end
`ifdef ALU_CTRL_PIPE_EN
            ST_CAPT: begin
                capture    = 1'b1;
                cap_result = pipe_result_q;
                cap_flags  = pipe_flags_q;
                state_d    = ST_DONE;
            end
`endif
            ST_DONE: begin
                ready_c = res_ready;
                if (res_ready) begin
                    op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A response handshake and a new acceptance may share the same DONE cycle.
        accept = ready_c && req_valid;
        if (accept) begin
            opcode_d  = req_opcode;
            cond_d    = req_cond;
            srctrl_d  = req_srctrl;
            s_d       = req_s;
            imvalue_d = req_imvalue;
            in1_d     = req_in1;
            in2_d     = req_in2;
            state_d   = ST_EXEC;
        end

        if (capture) begin
            res_data_d = (opcode_q == OP_NOP) ? '0 : cap_result;
            if (s_q && (opcode_q != OP_NOP)) begin
                flags_d = cap_flags;
            end
        end

        // Clear beats a concurrent flags write; res_flags reports what flags actually becomes.
        if (flags_clr) begin
            flags_d = 4'h0;
        end
        if (capture) begin
            res_flags_d = flags_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            opcode_q    <= '0;
            cond_q      <= '0;
            srctrl_q    <= '0;
            s_q         <= 1'b0;
            imvalue_q   <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            flags_q     <= '0;
            op_count_q  <= '0;
`ifdef ALU_CTRL_PIPE_EN
            pipe_result_q <= '0;
            pipe_flags_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            cond_q      <= cond_d;
            srctrl_q    <= srctrl_d;
            s_q         <= s_d;
            imvalue_q   <= imvalue_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            res_data_q  <= res_data_d;
            res_flags_q <= res_flags_d;
            flags_q     <= flags_d;
            op_count_q  <= op_count_d;
`ifdef ALU_CTRL_PIPE_EN
            pipe_result_q <= pipe_result_d;
            pipe_flags_q  <= pipe_flags_d;
`endif
        end
    end

    assign req_ready   = ready_c && !rst;
    assign res_valid   = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign res_data    = res_data_q;
    assign res_flags   = res_flags_q;
    assign flags       = flags_q;
    assign op_count    = op_count_q;

    assign alu_in1     = in1_q;
    assign alu_in2     = in2_q;
    assign alu_s       = s_q;
    assign alu_cond    = cond_q;
    assign alu_opcode  = opcode_q;
    assign alu_srctrl  = srctrl_q;
    assign alu_imvalue = imvalue_q;
    assign alu_inflags = flags_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: stand-in ALU, transaction-level model, directed and random phases.
module tb_alu_ctrl;
    localparam int W  = 32;
    localparam int CW = 6;
`ifdef ALU_CTRL_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          rst;
    logic          req_valid, req_ready;
    logic [3:0]    req_opcode, req_cond;
    logic [2:0]    req_srctrl;
    logic          req_s;
    logic [15:0]   req_imvalue;
    logic [W-1:0]  req_in1, req_in2;
    logic          res_valid, res_ready;
    logic [W-1:0]  res_data;
    logic [3:0]    res_flags;
    logic [W-1:0]  alu_in1, alu_in2;
    logic          alu_s;
    logic [3:0]    alu_cond, alu_opcode;
    logic [2:0]    alu_srctrl;
    logic [15:0]   alu_imvalue;
    logic [3:0]    alu_inflags, alu_outflags;
    logic [W-1:0]  alu_result;
    logic [3:0]    flags;
    logic          flags_clr;
    logic          busy;
    logic [CW-1:0] op_count;

    int n_pass = 0;
    int n_total = 0;

    alu_ctrl #(.W(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_cond(req_cond), .req_srctrl(req_srctrl),
        .req_s(req_s), .req_imvalue(req_imvalue), .req_in1(req_in1), .req_in2(req_in2),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_flags(res_flags),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_s(alu_s), .alu_cond(alu_cond),
        .alu_opcode(alu_opcode), .alu_srctrl(alu_srctrl), .alu_imvalue(alu_imvalue),
        .alu_inflags(alu_inflags), .alu_outflags(alu_outflags), .alu_result(alu_result),
        .flags(flags), .flags_clr(flags_clr), .busy(busy), .op_count(op_count)
    );

    // Stand-in combinational ALU: returns {flags, result}.
    function automatic logic [35:0] fake_alu(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op, input logic [3:0] cond,
                                             input logic [2:0] sr, input logic [15:0] imv,
                                             input logic [3:0] fin);
        logic [31:0] r;
        case (op)
            4'h0:    r = a + b;
            4'h1:    r = a - b;
            4'h2:    r = a & b;
            4'h3:    r = a | b;
            4'h4:    r = a ^ b;
            4'h8:    r = a - b;
            default: r = (a >> sr) + {16'h0, imv} + {28'h0, fin};
        endcase
        return {(r == 32'd0), r[31], ^r, fin[0] ^ cond[0], r};
    endfunction

    assign {alu_outflags, alu_result} = fake_alu(alu_in1, alu_in2, alu_opcode, alu_cond,
                                                 alu_srctrl, alu_imvalue, alu_inflags);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Transaction-level model: stage 0 idle, 1..LAT computing, LAT+1 response pending.
    int            m_stage = 0;
    logic [3:0]    m_flags = '0;
    logic [CW-1:0] m_cnt = '0;
    logic [W-1:0]  m_res_data = '0;
    logic [3:0]    m_res_flags = '0;
    logic [35:0]   m_alu = '0;
    logic [3:0]    m_opc = '0, m_cond = '0;
    logic [2:0]    m_sr = '0;
    logic          m_s = 1'b0;
    logic [15:0]   m_imv = '0;
    logic [W-1:0]  m_a = '0, m_b = '0;
    logic          m_take;

    always @(posedge clk) begin
        if (rst) begin
            m_stage = 0; m_flags = '0; m_cnt = '0; m_res_data = '0; m_res_flags = '0;
            m_opc = '0; m_cond = '0; m_sr = '0; m_s = 1'b0; m_imv = '0; m_a = '0; m_b = '0;
        end else begin
            m_take = 1'b0;
            if (m_stage == 1) m_alu = fake_alu(m_a, m_b, m_opc, m_cond, m_sr, m_imv, m_flags);
            if (m_stage == LAT && m_s && m_opc != 4'hF) m_flags = m_alu[35:32];
            if (flags_clr) m_flags = 4'h0;
            if (m_stage == LAT) begin
                m_res_data  = (m_opc == 4'hF) ? '0 : m_alu[31:0];
                m_res_flags = m_flags;
            end
            if (m_stage == 0) begin
                m_take = req_valid;
            end else if (m_stage == LAT + 1) begin
                if (res_ready) begin
                    m_cnt = m_cnt + 1'b1;
                    m_take = req_valid;
                    m_stage = 0;
                end
            end else begin
                m_stage = m_stage + 1;
            end
            if (m_take) begin
                m_opc = req_opcode; m_cond = req_cond; m_sr = req_srctrl; m_s = req_s;
                m_imv = req_imvalue; m_a = req_in1; m_b = req_in2;
                m_stage = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("req_ready", req_ready,
            !rst && (m_stage == 0 || (m_stage == LAT + 1 && res_ready)));
        chk("res_valid", res_valid, m_stage == LAT + 1);
        chk("busy", busy, m_stage != 0);
        chk("flags", flags, m_flags);
        chk("op_count", op_count, m_cnt);
        chk("alu_in1", alu_in1, m_a);
        chk("alu_in2", alu_in2, m_b);
        chk("alu_ops", {alu_opcode, alu_cond, alu_srctrl, alu_s, alu_imvalue},
            {m_opc, m_cond, m_sr, m_s, m_imv});
        chk("alu_inflags", alu_inflags, m_flags);
        if (m_stage == LAT + 1) begin
            chk("res_data", res_data, m_res_data);
            chk("res_flags", res_flags, m_res_flags);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic s);
        req_opcode = op; req_in1 = a; req_in2 = b; req_s = s;
        req_cond = 4'h0; req_srctrl = 3'd0; req_imvalue = 16'h0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic take_resp();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0; flags_clr = 1'b0;
        req_opcode = '0; req_cond = '0; req_srctrl = '0; req_s = 1'b0;
        req_imvalue = '0; req_in1 = '0; req_in2 = '0;
        tick();
        @(negedge clk);
        chk("rst_outputs", {req_ready, res_valid, busy, flags, op_count, res_data, alu_in1}, '0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 1'b1);

        // CMP 10,10 with flag write: result 0 -> flags {Z}=4'h8
        send(4'h8, 32'd10, 32'd10, 1'b1);
        repeat (LAT) tick();
        @(negedge clk);
        chk("cmp_valid", res_valid, 1'b1);
        chk("cmp_data", res_data, 32'd0);
        chk("cmp_flags", flags, 4'h8);
        chk("cmp_res_flags", res_flags, 4'h8);
        take_resp();
        @(negedge clk);
        chk("cmp_count", op_count, 1);

        // CMP without flag write
        send(4'h8, 32'd7, 32'd3, 1'b0);
        repeat (LAT) tick();
        @(negedge clk);
        chk("cmp_ns_data", res_data, 32'd4);
        chk("cmp_ns_flags", flags, 4'h8);
        take_resp();

        // NOP
        send(4'hF, 32'd5, 32'd33, 1'b1);
        repeat (LAT) tick();
        @(negedge clk);
        chk("nop_valid", res_valid, 1'b1);
        chk("nop_data", res_data, 32'd0);
        chk("nop_flags", flags, 4'h8);
        take_resp();

        // Back-pressure then back-to-back acceptance
        send(4'h0, 32'd1, 32'd2, 1'b0);
        repeat (LAT) tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_data", res_data, 32'd3);
            chk("bp_ready", req_ready, 1'b0);
            tick();
        end
        res_ready = 1'b1;
        req_valid = 1'b1; req_opcode = 4'h0; req_in1 = 32'd0; req_in2 = 32'hFFFF_FFFF; req_s = 1'b1;
        @(negedge clk);
        chk("b2b_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        chk("b2b_exec", {busy, res_valid}, 2'b10);
        chk("b2b_in2", alu_in2, 32'hFFFF_FFFF);
        repeat (LAT) tick();
        @(negedge clk);
        chk("b2b_data", res_data, 32'hFFFF_FFFF);
        chk("b2b_flags", flags, 4'h4);
        take_resp();

        // flags_clr beats a flag write in the capture cycle
        send(4'h8, 32'd10, 32'd10, 1'b1);
        repeat (LAT - 1) tick();
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        @(negedge clk);
        chk("clr_flags", flags, 4'h0);
        chk("clr_valid", res_valid, 1'b1);
        take_resp();

        // Reset while a response is pending
        send(4'h1, 32'd9, 32'd4, 1'b1);
        repeat (LAT) tick();
        @(negedge clk);
        chk("mid_valid", res_valid, 1'b1);
        rst = 1'b1; res_ready = 1'b1;
        tick();
        rst = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        chk("mid_rst", {res_valid, flags, op_count}, '0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            req_valid   = ($urandom_range(0, 2) != 0);
            res_ready   = ($urandom_range(0, 3) != 0);
            flags_clr   = ($urandom_range(0, 9) == 0);
            rst         = ($urandom_range(0, 999) == 0);
            req_opcode  = 4'($urandom_range(0, 15));
            req_cond    = 4'($urandom);
            req_srctrl  = 3'($urandom);
            req_s       = 1'($urandom);
            req_imvalue = 16'($urandom);
            req_in1     = $urandom;
            req_in2     = ($urandom_range(0, 3) == 0) ? req_in1 : $urandom;
            tick();
        end
        rst = 1'b0; req_valid = 1'b0; flags_clr = 1'b0;
        tick();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
